// File: rtl/cv32e40p_fpu_pkg.sv
// Shared FPU types (FPnew-compatible operation/format encodings) and the request
// bundle used when several cores share one FPU.
package cv32e40p_fpu_pkg;

  localparam int OP_BITS        = 4;
  localparam int FP_FORMAT_BITS = 3;
  localparam int NUM_FFLAGS     = 5;
  localparam int C_FLEN         = 32;

  typedef enum logic [OP_BITS-1:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [FP_FORMAT_BITS-1:0] {
    FP32, FP64, FP16, FP8, FP16ALT
  } fp_format_e;

  typedef enum logic {
    ARB,
    HOLD
  } arb_state_e;

  typedef struct packed {
    logic [2:0][C_FLEN-1:0] operands;
    operation_e             op;
    logic                   op_mod;
    fp_format_e             fmt;
    logic [2:0]             rm;
  } fpu_req_t;

  // Ops that occupy the single iterative div/sqrt unit
  function automatic logic is_divsqrt(operation_e op);
    return (op == DIV) || (op == SQRT);
  endfunction

endpackage

// File: rtl/cv32e40p_rr_arbiter.sv
// Round-robin priority select: returns the first set request at or after ptr_i,
// scanning circularly over NUM_REQ entries.
module cv32e40p_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               gnt_valid_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  int idx;

  // Scan from the farthest offset down so the closest hit to ptr_i is written last
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = ptr_i;
    idx         = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/cv32e40p_fpu_share_arbiter.sv
// Shares one FPU between NUM_REQ cores: round-robin grant held until handshake,
// per-requester outstanding limit, results routed back by tag.
// Define CV32E40P_FPU_ARB_DIVSQRT_BLOCK_EN to keep DIV/SQRT from double-booking the iterative unit.
module cv32e40p_fpu_share_arbiter
  import cv32e40p_fpu_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int FLEN      = 32,
  parameter int MAX_OUTST = 2,
  parameter int TAG_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ*3*FLEN-1:0]           req_operands_i,
  input  logic [NUM_REQ*OP_BITS-1:0]          req_op_i,
  input  logic [NUM_REQ-1:0]                  req_op_mod_i,
  input  logic [NUM_REQ*FP_FORMAT_BITS-1:0]   req_fmt_i,
  input  logic [NUM_REQ*3-1:0]                req_rm_i,
  output logic                                fpu_valid_o,
  input  logic                                fpu_ready_i,
  output logic [3*FLEN-1:0]                   fpu_operands_o,
  output logic [OP_BITS-1:0]                  fpu_op_o,
  output logic                                fpu_op_mod_o,
  output logic [FP_FORMAT_BITS-1:0]           fpu_fmt_o,
  output logic [2:0]                          fpu_rm_o,
  output logic [TAG_W-1:0]                    fpu_tag_o,
  input  logic                                fpu_out_valid_i,
  input  logic [TAG_W-1:0]                    fpu_tag_i,
  input  logic [FLEN-1:0]                     fpu_result_i,
  input  logic [NUM_FFLAGS-1:0]               fpu_flags_i,
  output logic                                fpu_out_ready_o,
  output logic [NUM_REQ-1:0]                  rsp_valid_o,
  output logic [FLEN-1:0]                     rsp_result_o,
  output logic [NUM_FFLAGS-1:0]               rsp_flags_o
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  if (FLEN != C_FLEN) begin : g_flen_check
    $error("FLEN must equal cv32e40p_fpu_pkg::C_FLEN");
  end

  arb_state_e                        state_q, state_d;
  logic [TAG_W-1:0]                  lock_idx_q, lock_idx_d;
  logic [TAG_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0][CNT_W-1:0]     outst_cnt_q, outst_cnt_d;

  fpu_req_t [NUM_REQ-1:0]            req_arr;
  fpu_req_t                          sel_req;
  logic [NUM_REQ-1:0]                eligible, cnt_inc, cnt_dec;
  logic                              gnt_valid, locked, accept, rsp_ok;
  logic [TAG_W-1:0]                  gnt_idx, sel_idx;

`ifdef CV32E40P_FPU_ARB_DIVSQRT_BLOCK_EN
  logic                              divsqrt_busy_q, divsqrt_busy_d;
  logic [TAG_W-1:0]                  divsqrt_tag_q, divsqrt_tag_d;
`endif

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_arr[i].operands = req_operands_i[i*3*FLEN +: 3*FLEN];
      req_arr[i].op       = operation_e'(req_op_i[i*OP_BITS +: OP_BITS]);
      req_arr[i].op_mod   = req_op_mod_i[i];
      req_arr[i].fmt      = fp_format_e'(req_fmt_i[i*FP_FORMAT_BITS +: FP_FORMAT_BITS]);
      req_arr[i].rm       = req_rm_i[i*3 +: 3];
      eligible[i]         = req_valid_i[i] && (outst_cnt_q[i] < CNT_W'(MAX_OUTST));
`ifdef CV32E40P_FPU_ARB_DIVSQRT_BLOCK_EN
      if (divsqrt_busy_q && is_divsqrt(req_arr[i].op)) eligible[i] = 1'b0;
`endif
    end
  end

  cv32e40p_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (TAG_W)
  ) u_rr_arbiter (
    .req_i       (eligible),
    .ptr_i       (rr_ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // Handshake semantics: a request transfers to the FPU in the cycle where
  // fpu_valid_o && fpu_ready_i; req_ready_o pulses for exactly that requester.
  // Once offered, a grant is frozen (HOLD) until the FPU takes it.
  assign locked      = (state_q == HOLD);
  assign sel_idx     = !rst_n ? '0 : (locked ? lock_idx_q : gnt_idx);
  assign sel_req     = req_arr[sel_idx];
  assign fpu_valid_o = rst_n && (locked ? req_valid_i[lock_idx_q] : gnt_valid);
  assign accept      = fpu_valid_o && fpu_ready_i;
  assign rsp_ok      = rst_n && fpu_out_valid_i && (int'(fpu_tag_i) < NUM_REQ);

  assign fpu_operands_o  = sel_req.operands;
  assign fpu_op_o        = sel_req.op;
  assign fpu_op_mod_o    = sel_req.op_mod;
  assign fpu_fmt_o       = sel_req.fmt;
  assign fpu_rm_o        = sel_req.rm;
  assign fpu_tag_o       = sel_idx;
  assign fpu_out_ready_o = 1'b1;
  assign rsp_result_o    = fpu_result_i;
  assign rsp_flags_o     = fpu_flags_i;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready_o[i] = accept && (sel_idx == TAG_W'(i));
      rsp_valid_o[i] = rsp_ok && (fpu_tag_i == TAG_W'(i));
      cnt_inc[i]     = req_ready_o[i];
      cnt_dec[i]     = rsp_valid_o[i] && (outst_cnt_q[i] != '0);
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_idx_d  = lock_idx_q;
    rr_ptr_d    = rr_ptr_q;
    outst_cnt_d = outst_cnt_q;
    case (state_q)
      ARB: begin
        if (gnt_valid && !fpu_ready_i) begin
          state_d    = HOLD;
          lock_idx_d = gnt_idx;
        end
      end
      HOLD:    if (fpu_ready_i) state_d = ARB;
      default: state_d = ARB;
    endcase
    if (accept) rr_ptr_d = (sel_idx == TAG_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cnt_inc[i] && !cnt_dec[i])      outst_cnt_d[i] = outst_cnt_q[i] + 1'b1;
      else if (cnt_dec[i] && !cnt_inc[i]) outst_cnt_d[i] = outst_cnt_q[i] - 1'b1;
    end
  end

`ifdef CV32E40P_FPU_ARB_DIVSQRT_BLOCK_EN
  // A new DIV/SQRT accept wins over a same-cycle completion of the previous one
  always_comb begin
    divsqrt_busy_d = divsqrt_busy_q;
    divsqrt_tag_d  = divsqrt_tag_q;
    if (accept && is_divsqrt(sel_req.op)) begin
      divsqrt_busy_d = 1'b1;
      divsqrt_tag_d  = sel_idx;
    end else if (divsqrt_busy_q && rsp_ok && (fpu_tag_i == divsqrt_tag_q)) begin
      divsqrt_busy_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ARB;
      lock_idx_q     <= '0;
      rr_ptr_q       <= '0;
      outst_cnt_q    <= '0;
`ifdef CV32E40P_FPU_ARB_DIVSQRT_BLOCK_EN
      divsqrt_busy_q <= 1'b0;
      divsqrt_tag_q  <= '0;
`endif
    end else begin
      state_q        <= state_d;
      lock_idx_q     <= lock_idx_d;
      rr_ptr_q       <= rr_ptr_d;
      outst_cnt_q    <= outst_cnt_d;
`ifdef CV32E40P_FPU_ARB_DIVSQRT_BLOCK_EN
      divsqrt_busy_q <= divsqrt_busy_d;
      divsqrt_tag_q  <= divsqrt_tag_d;
`endif
    end
  end

  a_tag_range: assert property (@(posedge clk) disable iff (!rst_n)
    fpu_out_valid_i |-> (int'(fpu_tag_i) < NUM_REQ));
  a_rsp_has_outst: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_ok |-> (outst_cnt_q[fpu_tag_i] != '0));

endmodule

// File: tb/tb_cv32e40p_fpu_share_arbiter.sv
// Directed and random checks of the shared-FPU arbiter against a queue-based reference model.
module tb_cv32e40p_fpu_share_arbiter;
  import cv32e40p_fpu_pkg::*;

  localparam int NREQ  = 2;
  localparam int FLEN  = 32;
  localparam int MAXO  = 2;
  localparam int TAG_W = 1;

  logic                              clk = 1'b0;
  logic                              rst_n;
  logic [NREQ-1:0]                   req_valid;
  logic [NREQ-1:0]                   req_ready;
  logic [NREQ*3*FLEN-1:0]            req_operands;
  logic [NREQ*OP_BITS-1:0]           req_op;
  logic [NREQ-1:0]                   req_op_mod;
  logic [NREQ*FP_FORMAT_BITS-1:0]    req_fmt;
  logic [NREQ*3-1:0]                 req_rm;
  logic                              fpu_valid;
  logic                              fpu_ready;
  logic [3*FLEN-1:0]                 fpu_operands;
  logic [OP_BITS-1:0]                fpu_op;
  logic                              fpu_op_mod;
  logic [FP_FORMAT_BITS-1:0]         fpu_fmt;
  logic [2:0]                        fpu_rm;
  logic [TAG_W-1:0]                  fpu_tag;
  logic                              fpu_out_valid;
  logic [TAG_W-1:0]                  fpu_tag_in;
  logic [FLEN-1:0]                   fpu_result;
  logic [NUM_FFLAGS-1:0]             fpu_flags;
  logic                              fpu_out_ready;
  logic [NREQ-1:0]                   rsp_valid;
  logic [FLEN-1:0]                   rsp_result;
  logic [NUM_FFLAGS-1:0]             rsp_flags;

  cv32e40p_fpu_share_arbiter #(
    .NUM_REQ   (NREQ),
    .FLEN      (FLEN),
    .MAX_OUTST (MAXO),
    .TAG_W     (TAG_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_operands_i  (req_operands),
    .req_op_i        (req_op),
    .req_op_mod_i    (req_op_mod),
    .req_fmt_i       (req_fmt),
    .req_rm_i        (req_rm),
    .fpu_valid_o     (fpu_valid),
    .fpu_ready_i     (fpu_ready),
    .fpu_operands_o  (fpu_operands),
    .fpu_op_o        (fpu_op),
    .fpu_op_mod_o    (fpu_op_mod),
    .fpu_fmt_o       (fpu_fmt),
    .fpu_rm_o        (fpu_rm),
    .fpu_tag_o       (fpu_tag),
    .fpu_out_valid_i (fpu_out_valid),
    .fpu_tag_i       (fpu_tag_in),
    .fpu_result_i    (fpu_result),
    .fpu_flags_i     (fpu_flags),
    .fpu_out_ready_o (fpu_out_ready),
    .rsp_valid_o     (rsp_valid),
    .rsp_result_o    (rsp_result),
    .rsp_flags_o     (rsp_flags)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: in-flight tags in FPU order, pointer, lock, per-requester counts
  logic [TAG_W-1:0] exp_q[$];
  int  ptr_m;
  bit  lock_m;
  int  lidx_m;
  int  cnt_m[NREQ];
  bit  busy_m;
  int  dtag_m;
  bit  ret;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic bit is_ds(input int i);
    logic [OP_BITS-1:0] op;
    op = req_op[i*OP_BITS +: OP_BITS];
    return (op == DIV) || (op == SQRT);
  endfunction

  function automatic bit elig(input int i);
    if (!req_valid[i] || cnt_m[i] >= MAXO) return 1'b0;
`ifdef CV32E40P_FPU_ARB_DIVSQRT_BLOCK_EN
    if (busy_m && is_ds(i)) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic int pick();
    for (int k = 0; k < NREQ; k++) begin
      if (elig((ptr_m + k) % NREQ)) return (ptr_m + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic reset_model();
    ptr_m = 0; lock_m = 0; lidx_m = 0; busy_m = 0; dtag_m = 0;
    for (int i = 0; i < NREQ; i++) cnt_m[i] = 0;
    exp_q.delete();
  endtask

  // Driver tasks
  task automatic set_req(input int i, input operation_e op);
    req_operands[i*3*FLEN +: 3*FLEN]             = {$urandom, $urandom, $urandom};
    req_op[i*OP_BITS +: OP_BITS]                 = op;
    req_op_mod[i]                                = 1'($urandom);
    req_fmt[i*FP_FORMAT_BITS +: FP_FORMAT_BITS]  = FP_FORMAT_BITS'($urandom_range(0, 4));
    req_rm[i*3 +: 3]                             = 3'($urandom);
  endtask

  function automatic operation_e rand_op();
    case ($urandom_range(0, 4))
      0:       return FMADD;
      1:       return ADD;
      2:       return MUL;
      3:       return DIV;
      default: return SQRT;
    endcase
  endfunction

  // One clock: drive response, check outputs at negedge, advance model at posedge
  task automatic step(input string name);
    int g, sel;
    bit ev;
    logic [NREQ-1:0] er, ersp;
    if (ret && exp_q.size() > 0) begin
      fpu_out_valid = 1'b1;
      fpu_tag_in    = exp_q[0];
    end else begin
      fpu_out_valid = 1'b0;
      fpu_tag_in    = '0;
    end
    fpu_result = $urandom;
    fpu_flags  = NUM_FFLAGS'($urandom);
    @(negedge clk);
    if (!rst_n) begin
      chk({name, ":rst_valid"}, fpu_valid, 0);
      chk({name, ":rst_ready"}, req_ready, 0);
      chk({name, ":rst_rsp"}, rsp_valid, 0);
      chk({name, ":rst_tag"}, fpu_tag, 0);
      chk({name, ":rst_opnd"}, fpu_operands, req_operands[0 +: 3*FLEN]);
      reset_model();
    end else begin
      g   = pick();
      sel = lock_m ? lidx_m : g;
      ev  = lock_m ? req_valid[lidx_m] : (g >= 0);
      er  = '0;
      if (ev && fpu_ready) er[sel] = 1'b1;
      ersp = '0;
      if (fpu_out_valid) ersp[fpu_tag_in] = 1'b1;
      if (lock_m) chk({name, ":no_retract"}, req_valid[lidx_m], 1);
      chk({name, ":fpu_valid"}, fpu_valid, ev);
      chk({name, ":req_ready"}, req_ready, er);
      chk({name, ":rsp_valid"}, rsp_valid, ersp);
      chk({name, ":out_ready"}, fpu_out_ready, 1);
      if (ev) begin
        chk({name, ":tag"}, fpu_tag, sel);
        chk({name, ":operands"}, fpu_operands, req_operands[sel*3*FLEN +: 3*FLEN]);
        chk({name, ":ctl"}, {fpu_op, fpu_op_mod, fpu_fmt, fpu_rm},
            {req_op[sel*OP_BITS +: OP_BITS], req_op_mod[sel],
             req_fmt[sel*FP_FORMAT_BITS +: FP_FORMAT_BITS], req_rm[sel*3 +: 3]});
      end
      if (fpu_out_valid) begin
        chk({name, ":result"}, rsp_result, fpu_result);
        chk({name, ":flags"}, rsp_flags, fpu_flags);
        if (cnt_m[fpu_tag_in] > 0) cnt_m[fpu_tag_in]--;
        if (busy_m && int'(fpu_tag_in) == dtag_m) busy_m = 1'b0;
        void'(exp_q.pop_front());
      end
      if (ev && fpu_ready) begin
        if (is_ds(sel)) begin busy_m = 1'b1; dtag_m = sel; end
        ptr_m = (sel + 1) % NREQ;
        cnt_m[sel]++;
        exp_q.push_back(TAG_W'(sel));
      end
      if (!lock_m && g >= 0 && !fpu_ready) begin
        lock_m = 1'b1;
        lidx_m = g;
      end else if (lock_m && fpu_ready) begin
        lock_m = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = '0;
    ret       = 1'b1;
    for (int k = 0; k < 2 * NREQ * MAXO + 2 && exp_q.size() > 0; k++) step("drain");
    ret = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; fpu_ready = 1'b0; ret = 1'b0;
    fpu_out_valid = 1'b0; fpu_tag_in = '0; fpu_result = '0; fpu_flags = '0;
    req_operands = '0; req_op = '0; req_op_mod = '0; req_fmt = '0; req_rm = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, ADD);
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    req_valid = '1;
    step("reset");
    rst_n = 1'b1; req_valid = '0;

    // Single request and its result
    set_req(0, ADD); req_valid = 2'b01; fpu_ready = 1'b1;
    step("single");
    req_valid = '0; ret = 1'b1;
    step("single_rsp");
    ret = 1'b0;

    // Round robin with continuous demand
    req_valid = 2'b11; fpu_ready = 1'b1; ret = 1'b1;
    repeat (4) step("rr");
    drain();

    // Grant hold while FPU stalls
    req_valid = 2'b10; fpu_ready = 1'b0;
    repeat (3) step("hold");
    req_valid = 2'b11;
    step("hold_late0");
    fpu_ready = 1'b1;
    step("hold_accept");
    step("hold_next");
    drain();

    // Outstanding limit
    req_valid = 2'b01; fpu_ready = 1'b1;
    repeat (2) step("outst_fill");
    req_valid = 2'b11;
    step("outst_other");
    req_valid = 2'b01;
    step("outst_block");
    ret = 1'b1;
    step("outst_rsp");
    ret = 1'b0;
    step("outst_again");
    ret = 1'b1; req_valid = 2'b01;
    step("outst_same_cycle");
    drain();

`ifdef CV32E40P_FPU_ARB_DIVSQRT_BLOCK_EN
    set_req(0, DIV); req_valid = 2'b01; fpu_ready = 1'b1;
    step("ds_div");
    set_req(1, SQRT); req_valid = 2'b10;
    step("ds_sqrt_stall");
    set_req(1, MUL);
    step("ds_mul");
    set_req(1, SQRT); ret = 1'b1;
    step("ds_div_rsp");
    ret = 1'b0;
    step("ds_sqrt_go");
    drain();
`endif

    // Async reset during HOLD with one op outstanding
    set_req(0, ADD); req_valid = 2'b01; fpu_ready = 1'b1;
    step("ar_issue");
    req_valid = 2'b10; fpu_ready = 1'b0;
    step("ar_lock");
    rst_n = 1'b0;
    #1;
    chk("ar_valid_now", fpu_valid, 0);
    chk("ar_ready_now", req_ready, 0);
    chk("ar_rsp_now", rsp_valid, 0);
    step("ar_in_reset");
    rst_n = 1'b1; req_valid = 2'b01; fpu_ready = 1'b1;
    repeat (3) step("ar_after");
    drain();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(lock_m && lidx_m == i)) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_req(i, rand_op());
        end
      end
      fpu_ready = ($urandom_range(0, 3) != 0);
      ret       = ($urandom_range(0, 2) != 0);
      step("rand");
    end
    fpu_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
